mc_ctrl_fsm: RTL

//   Parametrised multi-cycle MIPS main control FSM; the generalised successor of the

---
 rtl/mc_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control FSM.
// The FSM decodes the opcode from the instruction register and produces Moore-style
// datapath controls. Memory states handshake on mem_ready. A wait counter detects a
// stalled memory access, and a sticky TRAP state catches illegal opcodes and timeouts.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned MEM_TIMEOUT   = 16,
  parameter int unsigned EN_EXT_OPS    = 1,
  parameter int unsigned ILLEGAL_TRAP  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       branch_ne,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       immzext,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic       trap,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_IMMEX   = 4'd9;
  localparam logic [3:0] S_IMMWB   = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [3:0] S_BNEEX   = 4'd12;
  localparam logic [3:0] S_JALEX   = 4'd13;
  localparam logic [3:0] S_TRAP    = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0]  S_ILLEGAL = (ILLEGAL_TRAP != 0) ? S_TRAP : S_FETCH;
  localparam logic [31:0] WAIT_LAST = 32'(MEM_TIMEOUT - 1);

  logic [3:0]  state, next_state;
  logic [5:0]  op_q;
  logic [31:0] wait_cnt;
  logic        rdy, waiting, timed_out;
  logic        pcwrite_s, branch_s, branch_ne_s, irwrite_s, memwrite_s, regwrite_s;

  // Without the handshake every access completes in one cycle.
  assign rdy       = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign waiting   = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !rdy;
  assign timed_out = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == WAIT_LAST);

  // Opcode to first execute state; extended opcodes are illegal when disabled.
  function automatic logic [3:0] decode_op(input logic [5:0] o);
    logic [3:0] s;
    s = S_ILLEGAL;
    case (o)
      OP_LW, OP_SW: s = S_MEMADR;
      OP_RTYPE:     s = S_RTYPEEX;
      OP_BEQ:       s = S_BEQEX;
      OP_J:         s = S_JEX;
      OP_ADDI:      s = S_IMMEX;
      OP_BNE:       if (EN_EXT_OPS != 0) s = S_BNEEX;
      OP_SLTI, OP_ANDI, OP_ORI: if (EN_EXT_OPS != 0) s = S_IMMEX;
      OP_JAL:       if (EN_EXT_OPS != 0) s = S_JALEX;
      default:      s = S_ILLEGAL;
    endcase
    return s;
  endfunction

  // Next-state logic.
  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:   if (rdy) next_state = S_DECODE;
                 else if (timed_out) next_state = S_TRAP;
      S_DECODE:  next_state = decode_op(op);
      S_MEMADR:  next_state = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (rdy) next_state = S_MEMWB;
                 else if (timed_out) next_state = S_TRAP;
      S_MEMWR:   if (rdy) next_state = S_FETCH;
                 else if (timed_out) next_state = S_TRAP;
      S_RTYPEEX: next_state = S_RTYPEWB;
      S_IMMEX:   next_state = S_IMMWB;
      S_MEMWB, S_RTYPEWB, S_BEQEX, S_BNEEX, S_IMMWB, S_JEX, S_JALEX:
                 next_state = S_FETCH;
      S_TRAP:    next_state = S_TRAP;
      default:   next_state = S_FETCH;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Opcode is captured in DECODE so later states do not depend on the IR staying stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  op_q <= '0;
    else if (state == S_DECODE) op_q <= op;
  end

  // Counts consecutive not-ready cycles within one memory state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    wait_cnt <= '0;
    else if (next_state != state) wait_cnt <= '0;
    else if (waiting)             wait_cnt <= wait_cnt + 32'd1;
  end

  // Moore output decode from the current state, qualified by mem_ready in FETCH.
  always_comb begin
    pcwrite_s   = 1'b0;
    branch_s    = 1'b0;
    branch_ne_s = 1'b0;
    irwrite_s   = 1'b0;
    memwrite_s  = 1'b0;
    regwrite_s  = 1'b0;
    iord        = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    immzext     = 1'b0;
    regdst      = 2'b00;
    memtoreg    = 2'b00;
    pcsrc       = 2'b00;
    aluop       = 3'b000;
    case (state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        irwrite_s = rdy;
        pcwrite_s = rdy;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 2'b01;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 3'b010;
      end
      S_RTYPEWB: begin
        regwrite_s = 1'b1;
        regdst     = 2'b01;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca     = 1'b1;
        aluop       = 3'b001;
        pcsrc       = 2'b01;
        branch_s    = (state == S_BEQEX);
        branch_ne_s = (state == S_BNEEX);
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        immzext = (op_q == OP_ANDI) || (op_q == OP_ORI);
        case (op_q)
          OP_SLTI: aluop = 3'b101;
          OP_ANDI: aluop = 3'b011;
          OP_ORI:  aluop = 3'b100;
          default: aluop = 3'b000;
        endcase
      end
      S_IMMWB:   regwrite_s = 1'b1;
      S_JEX: begin
        pcwrite_s = 1'b1;
        pcsrc     = 2'b10;
      end
      S_JALEX: begin
        pcwrite_s  = 1'b1;
        pcsrc      = 2'b10;
        regwrite_s = 1'b1;
        regdst     = 2'b10;
        memtoreg   = 2'b10;
      end
      default: ;
    endcase
  end

  // Reset puts the FSM in FETCH at once; the write enables are masked so nothing fires meanwhile.
  assign pcwrite   = pcwrite_s   & ~reset;
  assign branch    = branch_s    & ~reset;
  assign branch_ne = branch_ne_s & ~reset;
  assign irwrite   = irwrite_s   & ~reset;
  assign memwrite  = memwrite_s  & ~reset;
  assign regwrite  = regwrite_s  & ~reset;
  assign trap      = (state == S_TRAP);
  assign state_o   = state;

endmodule
